// File: rtl/core_pkg.sv
// Shared types, defaults and helpers for the instruction fetch slice.
package core_pkg;

  localparam int FQ_XLEN = 32;
  localparam logic [FQ_XLEN-1:0] FQ_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [FQ_XLEN-1:0] word_align(input logic [FQ_XLEN-1:0] addr);
    return {addr[FQ_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_chk.sv
// Protocol and bookkeeping invariants for the fetch queue.
module fetch_queue_chk (
  input logic CLK,
  input logic RST,
  input logic rvalid,
  input logic outst_zero,
  input logic q_overflow,
  input logic tag_overflow,
  input logic tag_underflow,
  input logic tag_mismatch
);

  a_rvalid_needs_outst: assert property (@(posedge CLK) disable iff (RST) !(rvalid && outst_zero));
  a_queue_no_overflow:  assert property (@(posedge CLK) disable iff (RST) !q_overflow);
  a_tag_no_overflow:    assert property (@(posedge CLK) disable iff (RST) !tag_overflow);
  a_tag_no_underflow:   assert property (@(posedge CLK) disable iff (RST) !tag_underflow);
  a_tag_tracks_outst:   assert property (@(posedge CLK) disable iff (RST) !tag_mismatch);

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; push and pop may coincide at any fill level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH-1)) return {PW{1'b0}};
    else return p + PW'(1'b1);
  endfunction

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Pointer and occupancy tracking
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are qualified by count so no reset is needed
  always_ff @(posedge CLK) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues reads, queues returned words for decode.
module fetch_queue
  import core_pkg::*;
#(
  parameter int               XLEN      = FQ_XLEN,
  parameter int               DEPTH     = 4,
  parameter int               MAX_OUTST = 2,
  parameter logic [XLEN-1:0]  RESET_PC  = FQ_RESET_PC
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CORE_STALL,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            RCH1_REQ,
  output logic [XLEN-1:0] RCH1_ADDR,
  input  logic            RCH1_GNT,
  input  logic            RCH1_RVALID,
  input  logic [XLEN-1:0] RCH1_DATA,
  output logic            FETCH_VALID,
  output logic [XLEN-1:0] FETCH_PC,
  output logic [XLEN-1:0] FETCH_INSTR,
  input  logic            DECODE_READY
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTST+1);

  fetch_state_e         state_r, state_nxt_s;
  logic [XLEN-1:0]      pc_r;
  logic [OW-1:0]        outst_r, discard_r, inflight_s;
  logic                 rst_q_r, req_s, accept_s;
  logic                 q_push_s, q_pop_s, q_empty_s, q_full_s;
  logic [CW-1:0]        q_count_s;
  fetch_entry_t         q_in_s, q_head_s;
  logic [XLEN-1:0]      tag_head_s;
  logic [OW-1:0]        tag_count_s;
  logic                 tag_empty_s, tag_full_s;

  // Reads still owed by memory once this cycle's response (if any) lands
  assign inflight_s  = outst_r - OW'(RCH1_RVALID);
  assign accept_s    = req_s && RCH1_GNT;
  assign q_push_s    = RCH1_RVALID && (state_r == RUN) && !REDIRECT;
  assign q_pop_s     = !q_empty_s && DECODE_READY && !REDIRECT;
  assign q_in_s      = '{pc: tag_head_s, instr: RCH1_DATA};
  assign RCH1_REQ    = req_s;
  assign RCH1_ADDR   = pc_r;
  assign FETCH_VALID = !q_empty_s;
  assign FETCH_PC    = q_head_s.pc;
  assign FETCH_INSTR = q_head_s.instr;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_r <= RUN;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state: enter DRAIN while stale responses are owed
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (REDIRECT && (inflight_s != {OW{1'b0}})) state_nxt_s = DRAIN;
        else state_nxt_s = RUN;
      end
      DRAIN: begin
        if (REDIRECT) state_nxt_s = (inflight_s != {OW{1'b0}}) ? DRAIN : RUN;
        else if (discard_r == {OW{1'b0}}) state_nxt_s = RUN;
        else if (RCH1_RVALID && (discard_r == OW'(1'b1))) state_nxt_s = RUN;
        else state_nxt_s = DRAIN;
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // FSM output: issue only when queue space is reserved for every in-flight read
  always_comb begin
    req_s = 1'b0;
    if (!RST && !rst_q_r && !CORE_STALL && !REDIRECT && (state_r == RUN)
        && (int'(outst_r) < MAX_OUTST) && ((int'(q_count_s) + int'(outst_r)) < DEPTH)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  // PC, outstanding and discard counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      rst_q_r   <= 1'b1;
      pc_r      <= RESET_PC;
      outst_r   <= {OW{1'b0}};
      discard_r <= {OW{1'b0}};
    end else begin
      rst_q_r <= 1'b0;
      outst_r <= outst_r + OW'(accept_s) - OW'(RCH1_RVALID);
      if (REDIRECT) begin
        pc_r      <= word_align(REDIRECT_PC);
        discard_r <= inflight_s;
      end else begin
        if (accept_s) pc_r <= pc_r + XLEN'(3'd4);
        if ((state_r == DRAIN) && RCH1_RVALID) discard_r <= discard_r - OW'(1'b1);
      end
    end
  end

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (REDIRECT),
    .push      (q_push_s),
    .push_data (q_in_s),
    .pop       (q_pop_s),
    .head_data (q_head_s),
    .count     (q_count_s),
    .empty     (q_empty_s),
    .full      (q_full_s)
  );

  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_tags (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (REDIRECT),
    .push      (accept_s),
    .push_data (pc_r),
    .pop       (q_push_s),
    .head_data (tag_head_s),
    .count     (tag_count_s),
    .empty     (tag_empty_s),
    .full      (tag_full_s)
  );

  fetch_queue_chk u_chk (
    .CLK           (CLK),
    .RST           (RST),
    .rvalid        (RCH1_RVALID),
    .outst_zero    (outst_r == {OW{1'b0}}),
    .q_overflow    (q_push_s && q_full_s && !q_pop_s),
    .tag_overflow  (accept_s && tag_full_s),
    .tag_underflow (q_push_s && tag_empty_s),
    .tag_mismatch  ((state_r == RUN) && (tag_count_s != outst_r))
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order memory responder.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        fvalid;
  logic [31:0] fpc;
  logic [31:0] finstr;
  logic        dready = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] pend[$];
  int          n_checks = 0;
  int          n_fail = 0;

  fetch_queue dut (
    .CLK(clk), .RST(rst), .CORE_STALL(stall), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .RCH1_REQ(req), .RCH1_ADDR(addr), .RCH1_GNT(gnt), .RCH1_RVALID(rvalid), .RCH1_DATA(rdata),
    .FETCH_VALID(fvalid), .FETCH_PC(fpc), .FETCH_INSTR(finstr), .DECODE_READY(dready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: returns accepted reads in order, one cycle after accept unless held
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      rvalid <= 1'b0;
      rdata  <= 32'h0;
    end else begin
      if (req && gnt) pend.push_back(addr);
      if (!hold && pend.size() > 0) begin
        rvalid <= 1'b1;
        rdata  <= word_of(pend.pop_front());
      end else begin
        rvalid <= 1'b0;
        rdata  <= 32'h0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; gnt = 1'b0; dready = 1'b0; redirect = 1'b0; stall = 1'b0; hold = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; gnt = 1'b0; dready = 1'b0; redirect = 1'b0; stall = 1'b0; hold = 1'b0;
    step(); step();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
    n_checks++; if (fvalid !== 1'b0) begin n_fail++; $display("FAIL reset_fvalid: got %b want 0", fvalid); end
    rst = 1'b0;
    #1;
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL release_req0: got %b want 0", req); end
    n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL release_addr: got %h want 00000000", addr); end
    step();
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL release_req1: got %b want 1", req); end
    n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL release_addr1: got %h want 00000000", addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp = 32'h0;
    int w = 0;
    gnt = 1'b1; dready = 1'b1;
    while (!fvalid && w < 8) begin step(); w++; end
    n_checks++; if (fvalid !== 1'b1) begin n_fail++; $display("FAIL stream_timeout: fvalid %b want 1", fvalid); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (fvalid !== 1'b1 || fpc !== exp) begin
        n_fail++; $display("FAIL stream_pc[%0d]: got v=%b pc=%h want pc=%h", i, fvalid, fpc, exp); end
      n_checks++; if (finstr !== word_of(exp)) begin
        n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, finstr, word_of(exp)); end
      exp = exp + 32'h4;
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp = 32'h0;
    do_reset();
    gnt = 1'b1; dready = 1'b0;
    repeat (8) step();
    n_checks++; if (fvalid !== 1'b1 || fpc !== 32'h0) begin
      n_fail++; $display("FAIL bp_head: got v=%b pc=%h want pc=00000000", fvalid, fpc); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b want 0", req); end
    n_checks++; if (addr !== 32'h10) begin n_fail++; $display("FAIL bp_addr: got %h want 00000010", addr); end
    dready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp = exp + 32'h4;
      n_checks++; if (fvalid !== 1'b1 || fpc !== exp || finstr !== word_of(exp)) begin
        n_fail++; $display("FAIL bp_drain[%0d]: got v=%b pc=%h instr=%h want pc=%h", i, fvalid, fpc, finstr, exp); end
    end
  endtask

  task automatic test_redirect_inflight();
    int w = 0;
    do_reset();
    gnt = 1'b1; dready = 1'b1; hold = 1'b1;
    repeat (5) step();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL rdi_outst_req: got %b want 0", req); end
    redirect = 1'b1; redirect_pc = 32'h0000_0100; hold = 1'b0;
    step();
    redirect = 1'b0;
    #1;
    n_checks++; if (req !== 1'b0 || addr !== 32'h100) begin
      n_fail++; $display("FAIL rdi_drain0: got req=%b addr=%h want req=0 addr=00000100", req, addr); end
    n_checks++; if (fvalid !== 1'b0) begin n_fail++; $display("FAIL rdi_flush: got fvalid %b want 0", fvalid); end
    step();
    n_checks++; if (req !== 1'b0 || fvalid !== 1'b0) begin
      n_fail++; $display("FAIL rdi_drain1: got req=%b fvalid=%b want 0 0", req, fvalid); end
    step();
    n_checks++; if (req !== 1'b1 || addr !== 32'h100) begin
      n_fail++; $display("FAIL rdi_restart: got req=%b addr=%h want req=1 addr=00000100", req, addr); end
    while (!fvalid && w < 10) begin step(); w++; end
    n_checks++; if (fvalid !== 1'b1 || fpc !== 32'h100 || finstr !== word_of(32'h100)) begin
      n_fail++; $display("FAIL rdi_head: got v=%b pc=%h instr=%h want pc=00000100", fvalid, fpc, finstr); end
  endtask

  task automatic test_redirect_rvalid();
    int w = 0;
    do_reset();
    gnt = 1'b1; dready = 1'b1; hold = 1'b1;
    repeat (5) step();
    hold = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    redirect = 1'b0;
    #1;
    n_checks++; if (req !== 1'b0 || addr !== 32'h200 || fvalid !== 1'b0) begin
      n_fail++; $display("FAIL rdv_drop: got req=%b addr=%h fvalid=%b want 0 00000200 0", req, addr, fvalid); end
    step();
    n_checks++; if (req !== 1'b1 || addr !== 32'h200 || fvalid !== 1'b0) begin
      n_fail++; $display("FAIL rdv_restart: got req=%b addr=%h fvalid=%b want 1 00000200 0", req, addr, fvalid); end
    while (!fvalid && w < 10) begin step(); w++; end
    n_checks++; if (fvalid !== 1'b1 || fpc !== 32'h200 || finstr !== word_of(32'h200)) begin
      n_fail++; $display("FAIL rdv_head: got v=%b pc=%h instr=%h want pc=00000200", fvalid, fpc, finstr); end
  endtask

  task automatic test_stall_wrap();
    do_reset();
    hold = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0; gnt = 1'b1;
    #1;
    n_checks++; if (req !== 1'b1 || addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL sw_issue: got req=%b addr=%h want 1 fffffffc", req, addr); end
    step();
    stall = 1'b1;
    #1;
    n_checks++; if (req !== 1'b0 || addr !== 32'h0) begin
      n_fail++; $display("FAIL sw_wrap: got req=%b addr=%h want 0 00000000", req, addr); end
    repeat (3) step();
    n_checks++; if (req !== 1'b0 || fvalid !== 1'b0) begin
      n_fail++; $display("FAIL sw_stalled: got req=%b fvalid=%b want 0 0", req, fvalid); end
    hold = 1'b0;
    step(); step();
    n_checks++; if (fvalid !== 1'b1 || fpc !== 32'hFFFF_FFFC || finstr !== word_of(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL sw_deliver: got v=%b pc=%h instr=%h want pc=fffffffc", fvalid, fpc, finstr); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL sw_still_stalled: got %b want 0", req); end
    stall = 1'b0;
    #1;
    n_checks++; if (req !== 1'b1 || addr !== 32'h0) begin
      n_fail++; $display("FAIL sw_unstall: got req=%b addr=%h want 1 00000000", req, addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_stall_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
